// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the parameterised FIFO.
// Imported by the FIFO top and its storage sub-module.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, registered read.
// No reset on the array or the read register.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read sees the old word when both ports hit one address.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy count,
// almost flags and sticky overflow/underflow flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              over_flow,
    output logic              under_flow
);

    localparam logic [CW-1:0] AF_C = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LVL);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of 2, >= 4");
    end
    if (AE_LVL >= AF_LVL) begin : g_bad_ae
        $error("param_fifo: AE_LVL must be below AF_LVL");
    end
    if (AF_LVL > DEPTH) begin : g_bad_af
        $error("param_fifo: AF_LVL must not exceed DEPTH");
    end

    logic [CW-1:0]     wptr;
    logic [CW-1:0]     rptr;
    logic              wr_en;
    logic              rd_en;
    logic              have_data;
    logic [DATA_W-1:0] mem_q;
    fifo_status_t      stat;

    always_comb begin
        stat.full = (wptr[CW-1] != rptr[CW-1]) &&
                    (wptr[CW-2:0] == rptr[CW-2:0]);
        stat.empty        = (wptr == rptr);
        stat.almost_full  = (count >= AF_C);
        stat.almost_empty = (count <= AE_C);
    end

    assign full         = stat.full;
    assign empty        = stat.empty;
    assign almost_full  = stat.almost_full;
    assign almost_empty = stat.almost_empty;

    // A full FIFO still takes a write when a read frees the slot.
    assign wr_en = !wr_n && (!stat.full || !rd_n);
    assign rd_en = !rd_n && !stat.empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            have_data <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            if (rd_en) have_data <= 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            over_flow  <= 1'b0;
            under_flow <= 1'b0;
        end else begin
            over_flow <= (!wr_n && rd_n && stat.full) ||
                         (over_flow && !clr_flags);
            under_flow <= (!rd_n && stat.empty) ||
                          (under_flow && !clr_flags);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en),
        .waddr  (wptr[CW-2:0]),
        .wdata  (wdata),
        .re     (rd_en),
        .raddr  (rptr[CW-2:0]),
        .rdata  (mem_q)
    );

    // Read register is unreset, so mask it until a read lands.
    assign rdata = have_data ? mem_q : '0;

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (DEPTH=16, DATA_W=8).
// Vector table for fill/drain, hand sequences for corner cases.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       clr_flags = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       over_flow, under_flow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    param_fifo #(
        .DATA_W (8),
        .DEPTH  (16),
        .AF_LVL (14),
        .AE_LVL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_n         (wr_n),
        .rd_n         (rd_n),
        .wdata        (wdata),
        .clr_flags    (clr_flags),
        .rdata        (rdata),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .over_flow    (over_flow),
        .under_flow   (under_flow)
    );

    typedef struct {
        logic       wr_n;
        logic       rd_n;
        logic       clr;
        logic [7:0] wdata;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       of;
        logic       uf;
        logic [7:0] rdata;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] q[$];

    function automatic vec_t mk(
        input logic w, input logic r, input logic c,
        input logic [7:0] d, input int n,
        input logic f, input logic e,
        input logic af, input logic ae,
        input logic of, input logic uf,
        input logic [7:0] rd);
        vec_t v;
        v.wr_n = w;  v.rd_n = r;  v.clr = c;
        v.wdata = d; v.count = 5'(n);
        v.full = f;  v.empty = e;
        v.af = af;   v.ae = ae;
        v.of = of;   v.uf = uf;
        v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic c, input logic [7:0] d);
        wr_n = w;
        rd_n = r;
        clr_flags = c;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_n = 1'b1;
        rd_n = 1'b1;
        clr_flags = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst aempty", almost_empty, 1);
        chk("rst full", full, 0);
        chk("rst afull", almost_full, 0);
        chk("rst oflow", over_flow, 0);
        chk("rst uflow", under_flow, 0);
        chk("rst rdata", rdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 0, 8'(i), i + 1, i == 15, 0,
                             i + 1 >= 14, i + 1 <= 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hEE, 16, 1, 0, 1, 0, 1, 0, 0));
        for (int j = 0; j < 16; j++)
            tbl.push_back(mk(1, 0, 0, 0, 15 - j, 0, j == 15,
                             15 - j >= 14, 15 - j <= 2, 1, 0, 8'(j)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h0F));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 8'h0F));

        foreach (tbl[i]) begin
            drive(tbl[i].wr_n, tbl[i].rd_n, tbl[i].clr, tbl[i].wdata);
            chk($sformatf("v%0d count", i), count, tbl[i].count);
            chk($sformatf("v%0d full", i), full, tbl[i].full);
            chk($sformatf("v%0d empty", i), empty, tbl[i].empty);
            chk($sformatf("v%0d afull", i), almost_full, tbl[i].af);
            chk($sformatf("v%0d aempty", i), almost_empty, tbl[i].ae);
            chk($sformatf("v%0d oflow", i), over_flow, tbl[i].of);
            chk($sformatf("v%0d uflow", i), under_flow, tbl[i].uf);
            chk($sformatf("v%0d rdata", i), rdata, tbl[i].rdata);
        end
        idle();

        // Both strobes at full, then at empty.
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 8'(8'h10 + i));
        chk("fill full", full, 1);
        drive(0, 0, 0, 8'hA0);
        chk("rw@full count", count, 16);
        chk("rw@full full", full, 1);
        chk("rw@full oflow", over_flow, 0);
        chk("rw@full rdata", rdata, 8'h10);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0);
            chk($sformatf("drainA %0d", i), rdata,
                i == 15 ? 8'hA0 : 8'(8'h11 + i));
        end
        chk("drainA empty", empty, 1);
        drive(0, 0, 0, 8'hB0);
        chk("rw@empty count", count, 1);
        chk("rw@empty uflow", under_flow, 1);
        chk("rw@empty empty", empty, 0);
        chk("rw@empty rdata", rdata, 8'hA0);
        drive(1, 0, 0, 0);
        chk("rw@empty read", rdata, 8'hB0);
        chk("rw@empty cnt0", count, 0);
        drive(1, 1, 1, 0);
        chk("clr uflow", under_flow, 0);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'(8'h30 + i));
            q.push_back(8'(8'h30 + i));
        end
        for (int k = 0; k < 40; k++) begin
            logic [7:0] e;
            drive(0, 0, 0, 8'(8'h40 + k));
            q.push_back(8'(8'h40 + k));
            e = q.pop_front();
            chk($sformatf("wrap rd %0d", k), rdata, e);
            chk($sformatf("wrap cnt %0d", k), count, 3);
        end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            drive(1, 0, 0, 0);
            e = q.pop_front();
            chk($sformatf("wrap tail %0d", i), rdata, e);
        end
        chk("wrap empty", empty, 1);
        idle();

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 9; i++) drive(0, 1, 0, 8'(8'h60 + i));
        chk("pre-rst count", count, 9);
        idle();
        rst = 1'b1;
        #1;
        chk("mid-rst count", count, 0);
        chk("mid-rst empty", empty, 1);
        chk("mid-rst aempty", almost_empty, 1);
        chk("mid-rst rdata", rdata, 0);
        #1;
        rst = 1'b0;
        drive(0, 1, 0, 8'h55);
        chk("post-rst count", count, 1);
        drive(1, 0, 0, 0);
        chk("post-rst rdata", rdata, 8'h55);

        // Overflow clear, and clear racing a new overflow.
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 8'(8'h70 + i));
        drive(0, 1, 0, 8'hFF);
        chk("of set", over_flow, 1);
        chk("of count", count, 16);
        drive(1, 1, 1, 0);
        chk("of clr", over_flow, 0);
        drive(0, 1, 1, 8'hFE);
        chk("of clr+new", over_flow, 1);
        chk("of clr+new cnt", count, 16);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0);
            chk($sformatf("drainD %0d", i), rdata, 8'(8'h70 + i));
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of 2, 4..1024).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LVL, default 2, almost_empty threshold in entries.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_n, input, 1, active-low write strobe.
REQ-008 SHALL have port rd_n, input, 1, active-low read strobe.
REQ-009 SHALL have port wdata, input, DATA_W, write data.
REQ-010 SHALL have port clr_flags, input, 1, synchronous clear of the sticky error flags.
REQ-011 SHALL have port rdata, output, DATA_W, registered read data.
REQ-012 SHALL have ports full, empty, almost_full and almost_empty, each output, 1, status flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-014 SHALL have ports over_flow and under_flow, each output, 1, sticky error flags.

Function
REQ-015 SHALL accept a write on a rising edge with wr_n=0 and not full, or with wr_n=0, rd_n=0 and full.
REQ-016 SHALL accept a read on a rising edge with rd_n=0 and not empty.
REQ-017 SHALL present data from an accepted read on rdata one cycle after the read edge, and hold rdata otherwise.
REQ-018 SHALL use read and write pointers of $clog2(DEPTH)+1 bits with a wrap bit; full = MSBs differ and the rest are equal; empty = pointers equal.
REQ-019 SHALL update count as +1 on a write-only, -1 on a read-only, and unchanged on both or neither.
REQ-020 SHALL drive full, empty, almost_full (count>=AF_LVL) and almost_empty (count<=AE_LVL) from registered state, valid in the cycle after the causing edge.
REQ-021 SHALL, on full with both strobes asserted, accept both transfers, keep count at DEPTH and not flag overflow.
REQ-022 SHALL, on empty with both strobes asserted, accept the write, reject the read and set under_flow.
REQ-023 SHALL set over_flow one cycle after an edge with wr_n=0, full and rd_n=1; the rejected write leaves memory and pointers unchanged.
REQ-024 SHALL set under_flow one cycle after an edge with rd_n=0 and empty; the rejected read leaves rdata and pointers unchanged.
REQ-025 SHALL hold over_flow and under_flow until clr_flags=1 or reset; when clr_flags and a new error occur in the same cycle, the flag is set.
REQ-026 SHALL wrap pointers modulo 2*DEPTH with no data loss across the wrap.

Reset
REQ-027 SHALL, while rst=1, immediately drive the pointers and count to 0, empty=1, almost_empty=1, full=0, almost_full=0, over_flow=0, under_flow=0 and rdata=0.
REQ-028 SHALL discard contents on a reset asserted mid-operation; memory array contents are not reset, and the first read after reset returns the first post-reset write.

Structure
REQ-029 SHALL take shared constants (default DEPTH and DATA_W) and a fifo_status_t packed struct {full, empty, almost_full, almost_empty} from package fifo_pkg.
REQ-030 SHALL instantiate sub-module fifo_mem: a DEPTH x DATA_W array with a synchronous write port and a registered read port, without reset.
REQ-031 SHALL carry elaboration assertions rejecting a non-power-of-2 DEPTH, AE_LVL >= AF_LVL or AF_LVL > DEPTH.

Verification (DEPTH=16, DATA_W=8, AF_LVL=14, AE_LVL=2)
REQ-032 SHALL check: reset, then 16 writes of 0x00..0x0F -> full=1 and count=16; a 17th write -> over_flow=1 next cycle; count stays 16.
REQ-033 SHALL check: from full, 16 reads -> rdata 0x00..0x0F in order with 1-cycle latency and empty=1; a 17th read -> under_flow=1 next cycle.
REQ-034 SHALL check: count crossing 13 to 14 -> almost_full rises; count crossing 3 to 2 -> almost_empty rises.
REQ-035 SHALL check: simultaneous rd_n=0 and wr_n=0 at full -> count=16 and no over_flow; the same at empty -> count=1 and under_flow=1.
REQ-036 SHALL check: 40 interleaved write/read pairs (pointer wrap) -> data order preserved; rst pulse at count=9 -> count=0 and empty=1 immediately.
REQ-037 SHALL check: clr_flags=1 after an over_flow -> over_flow=0 next cycle; clr_flags coinciding with a new overflow -> over_flow=1.
